stat_config_regbank: RTL and testbench
======================================

STAT_CONFIG_REGBANK -- requirements
Module: stat_config_regbank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of event channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 10, per-direction counter width (1..16).
REQ-003 SHALL have parameter BASE_ADDR, default 32'hC0F16000, register bank base address.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports wen/waddr/wdata  input  1/32/32  register write request, address, data.
REQ-007 SHALL have ports ren/raddr  input  1/32  register read request, address.
REQ-008 SHALL have ports rdata/rvalid  output  32/1  read data and its valid strobe.
REQ-009 SHALL have ports rerr/werr  output  1/1  one-cycle unmapped-access error pulses.
REQ-010 SHALL have ports ev_rd/ev_wr  input  NUM_CH/NUM_CH  asynchronous per-channel event levels.
REQ-011 SHALL have ports cfg_count_en/cfg_wr_rd_ratio/cfg_use_merr_resp  output  1/3/1  control fields.
REQ-012 SHALL have port irq  output  1  level interrupt, |(irq_stat & irq_mask).

Function
REQ-013 Map: BASE+4*ch (ch<NUM_CH) CH_STAT RO read-to-clear, [CNT_W-1:0] wr_cnt, [2*CNT_W-1:CNT_W] rd_cnt, upper bits 0.
REQ-014 Map: BASE+0x100 CTRL RW, bit0 count_en, bits[3:1] wr_rd_ratio, bit4 use_merr_resp; BASE+0x104 THRESH RW [CNT_W-1:0]; BASE+0x108 IRQ_STAT W1C [NUM_CH-1:0]; BASE+0x10C IRQ_MASK RW [NUM_CH-1:0]; unimplemented bits read 0.
REQ-015 Each ev_rd/ev_wr bit SHALL pass a two-flop synchroniser then rising-edge detect, giving one one-cycle pulse per 0->1 transition, 3 cycles after the edge.
REQ-016 Counter SHALL increment by 1 per pulse when count_en=1, SHALL saturate at all-ones, never wrap.
REQ-017 Read: ren sampled at edge N; rdata and rvalid=1 valid after edge N; rvalid low otherwise; rdata=0 when rvalid=0.
REQ-018 CH_STAT read SHALL clear both counters of that channel at edge N; a pulse coinciding with the clear SHALL load 1, not 0.
REQ-019 Write SHALL take effect at edge of wen; simultaneous read of same address SHALL return pre-write value.
REQ-020 irq_stat[ch] SHALL set when either counter of ch transitions to value equal to THRESH; THRESH=0 disables setting.
REQ-021 IRQ_STAT write of 1 SHALL clear the bit; a set condition in the same cycle SHALL win.
REQ-022 Access to any address not in map SHALL pulse rerr/werr one cycle after request, rdata=0 with rvalid=1, no state change.
REQ-023 Simultaneous ren and wen to different addresses SHALL both complete in the same cycle.

Reset
REQ-024 On rstn low: all counters, THRESH, IRQ_STAT, IRQ_MASK, synchroniser flops, rdata, rvalid, rerr, werr, irq SHALL be 0; CTRL SHALL be 32'h1 (count_en=1, ratio 0, merr 0).
REQ-025 Reset mid-read SHALL suppress rvalid; event edges present at reset deassertion SHALL NOT count (sync flops start at 0, edge detector primed by first sampled value).

Structure
REQ-026 Offsets (CH_STAT, CTRL, THRESH, IRQ_STAT, IRQ_MASK) and CTRL field positions SHALL live in shared package regbank_pkg.
REQ-027 One sub-module event_sync_edge (two-flop sync + rising-edge pulse) SHALL be instantiated 2*NUM_CH times.
REQ-028 Elaboration SHALL reject 2*CNT_W>32 or NUM_CH>32.

Verification
REQ-029 Defaults: 3 ev_wr edges ch1 -> read BASE+4 returns 32'h3, immediate reread returns 0.
REQ-030 CNT_W=4: 20 ev_rd edges ch0 -> read BASE+0 returns 32'hF0 (saturated), no wrap.
REQ-031 Event pulse on clear edge: read BASE+8 aligned with ch2 pulse -> next read returns 32'h1.
REQ-032 THRESH=5, IRQ_MASK=1: 5 ev_wr edges ch0 -> irq=1, IRQ_STAT=1; write 1 to IRQ_STAT -> irq=0.
REQ-033 Read BASE+0x200 -> rerr=1 one cycle, rvalid=1, rdata=0; write BASE+0x2FC -> werr=1, CTRL unchanged 32'h1.
REQ-034 Write CTRL=0 then 4 ev_rd edges ch3 -> read BASE+0xC returns 0; rstn low mid-stream -> all outputs 0, CTRL reads 32'h1.

Source files
------------

// File: rtl/regbank_pkg.sv
// ============================================================================
// regbank_pkg : register offsets, CTRL field layout and address decode helper
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regbank_pkg;

  localparam logic [31:0] OFF_CH_STAT  = 32'h000;
  localparam logic [31:0] OFF_CTRL     = 32'h100;
  localparam logic [31:0] OFF_THRESH   = 32'h104;
  localparam logic [31:0] OFF_IRQ_STAT = 32'h108;
  localparam logic [31:0] OFF_IRQ_MASK = 32'h10C;

  localparam int CTRL_W         = 5;
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_RATIO_LSB = 1;
  localparam int CTRL_RATIO_W   = 3;
  localparam int CTRL_MERR_BIT  = 4;
  localparam logic [CTRL_W-1:0] CTRL_RESET = 5'h01;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CH,
    SEL_CTRL,
    SEL_THRESH,
    SEL_IRQ_STAT,
    SEL_IRQ_MASK
  } reg_sel_e;

  // off is the address relative to the bank base; unaligned offsets never map
  function automatic reg_sel_e decode_sel(input logic [31:0] off, input int unsigned num_ch);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (off[1:0] == 2'b00) begin
      if (off < 32'(4 * num_ch)) sel = SEL_CH;
      else begin
        case (off)
          OFF_CTRL:     sel = SEL_CTRL;
          OFF_THRESH:   sel = SEL_THRESH;
          OFF_IRQ_STAT: sel = SEL_IRQ_STAT;
          OFF_IRQ_MASK: sel = SEL_IRQ_MASK;
          default:      sel = SEL_NONE;
        endcase
      end
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/event_sync_edge.sv
// ============================================================================
// event_sync_edge : two-flop synchroniser followed by a registered rising-edge pulse
// Revision        : 1.0
// ============================================================================
`default_nettype none

module event_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic level,
  output logic pulse
);

  logic       meta;
  logic       sync;
  logic       prev;
  logic [2:0] fill;

  // fill[2] marks prev as holding a real sample, so a level already high
  // at reset release primes the detector instead of producing a pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      prev  <= 1'b0;
      fill  <= 3'b000;
      pulse <= 1'b0;
    end else begin
      meta  <= level;
      sync  <= meta;
      prev  <= sync;
      fill  <= {fill[1:0], 1'b1};
      pulse <= sync & ~prev & fill[2];
    end
  end

endmodule

`default_nettype wire

// File: rtl/stat_config_regbank.sv
// ============================================================================
// stat_config_regbank : per-channel read/write event counters with config and IRQ registers
// Revision            : 1.0
// ============================================================================
`default_nettype none

module stat_config_regbank
  import regbank_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 10,
  parameter logic [31:0] BASE_ADDR = 32'hC0F16000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wen,
  input  logic [31:0]       waddr,
  input  logic [31:0]       wdata,
  input  logic              ren,
  input  logic [31:0]       raddr,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              rerr,
  output logic              werr,
  input  logic [NUM_CH-1:0] ev_rd,
  input  logic [NUM_CH-1:0] ev_wr,
  output logic              cfg_count_en,
  output logic [2:0]        cfg_wr_rd_ratio,
  output logic              cfg_use_merr_resp,
  output logic              irq
);

  localparam int STAT_W = 2 * CNT_W;

  if (NUM_CH < 1 || NUM_CH > 32 || CNT_W < 1 || STAT_W > 32) begin : g_bad_params
    $error("stat_config_regbank: unsupported NUM_CH/CNT_W combination");
  end

  logic [31:0]       roff;
  logic [31:0]       woff;
  reg_sel_e          rsel;
  reg_sel_e          wsel;
  logic [CTRL_W-1:0] ctrl;
  logic [CNT_W-1:0]  thresh;
  logic [NUM_CH-1:0] irq_stat;
  logic [NUM_CH-1:0] irq_mask;
  logic [NUM_CH-1:0] hit_set;
  logic [NUM_CH-1:0] w1c;
  logic [STAT_W-1:0] ch_stat [NUM_CH];
  logic [31:0]       rd_val;
  logic              count_en;
  logic              unused_wdata;

  assign roff = raddr - BASE_ADDR;
  assign woff = waddr - BASE_ADDR;
  assign rsel = decode_sel(roff, NUM_CH);
  assign wsel = decode_sel(woff, NUM_CH);

  assign count_en          = ctrl[CTRL_EN_BIT];
  assign cfg_count_en      = count_en;
  assign cfg_wr_rd_ratio   = ctrl[CTRL_RATIO_LSB +: CTRL_RATIO_W];
  assign cfg_use_merr_resp = ctrl[CTRL_MERR_BIT];
  assign irq               = |(irq_stat & irq_mask);
  assign unused_wdata      = ^wdata;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic             pulse_rd;
    logic             pulse_wr;
    logic             clr;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_next;
    logic [CNT_W-1:0] rd_next;

    event_sync_edge u_sync_rd (.clk(clk), .rstn(rstn), .level(ev_rd[ch]), .pulse(pulse_rd));
    event_sync_edge u_sync_wr (.clk(clk), .rstn(rstn), .level(ev_wr[ch]), .pulse(pulse_wr));

    assign clr = ren && (rsel == SEL_CH) && (roff[6:2] == 5'(ch));

    // clear first, then count, so a pulse landing on the clear edge yields 1
    always_comb begin
      wr_next = clr ? '0 : wr_cnt;
      rd_next = clr ? '0 : rd_cnt;
      if (count_en && pulse_wr && (wr_next != '1)) wr_next = wr_next + CNT_W'(1);
      if (count_en && pulse_rd && (rd_next != '1)) rd_next = rd_next + CNT_W'(1);
    end

    assign hit_set[ch] = (thresh != '0) &&
                         (((wr_next != wr_cnt) && (wr_next == thresh)) ||
                          ((rd_next != rd_cnt) && (rd_next == thresh)));

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wr_cnt <= '0;
        rd_cnt <= '0;
      end else begin
        wr_cnt <= wr_next;
        rd_cnt <= rd_next;
      end
    end

    assign ch_stat[ch] = {rd_cnt, wr_cnt};
  end

  assign w1c = (wen && (wsel == SEL_IRQ_STAT)) ? wdata[NUM_CH-1:0] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl     <= CTRL_RESET;
      thresh   <= '0;
      irq_mask <= '0;
      irq_stat <= '0;
    end else begin
      if (wen && (wsel == SEL_CTRL))     ctrl     <= wdata[CTRL_W-1:0];
      if (wen && (wsel == SEL_THRESH))   thresh   <= wdata[CNT_W-1:0];
      if (wen && (wsel == SEL_IRQ_MASK)) irq_mask <= wdata[NUM_CH-1:0];
      irq_stat <= (irq_stat & ~w1c) | hit_set;
    end
  end

  always_comb begin
    rd_val = '0;
    case (rsel)
      SEL_CH: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (roff[6:2] == 5'(i)) rd_val = 32'(ch_stat[i]);
        end
      end
      SEL_CTRL:     rd_val = 32'(ctrl);
      SEL_THRESH:   rd_val = 32'(thresh);
      SEL_IRQ_STAT: rd_val = 32'(irq_stat);
      SEL_IRQ_MASK: rd_val = 32'(irq_mask);
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      rerr   <= 1'b0;
      werr   <= 1'b0;
    end else begin
      rdata  <= ren ? rd_val : '0;
      rvalid <= ren;
      rerr   <= ren && (rsel == SEL_NONE);
      werr   <= wen && (wsel == SEL_NONE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stat_config_regbank.sv
// ============================================================================
// tb_stat_config_regbank : directed self-checking bench, default and CNT_W=4 instances
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_stat_config_regbank;

  localparam logic [31:0] BASE = 32'hC0F16000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] raddr = '0;
  logic [3:0]  ev_rd = '0;
  logic [3:0]  ev_wr = '0;

  logic [31:0] rdata, rdata4;
  logic        rvalid, rvalid4, rerr, rerr4, werr, werr4;
  logic        en, en4, merr, merr4, irq, irq4;
  logic [2:0]  ratio, ratio4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  stat_config_regbank #(.NUM_CH(4), .CNT_W(10), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rstn(rstn), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .rerr(rerr), .werr(werr),
    .ev_rd(ev_rd), .ev_wr(ev_wr), .cfg_count_en(en), .cfg_wr_rd_ratio(ratio),
    .cfg_use_merr_resp(merr), .irq(irq)
  );

  stat_config_regbank #(.NUM_CH(4), .CNT_W(4), .BASE_ADDR(BASE)) dut4 (
    .clk(clk), .rstn(rstn), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata4), .rvalid(rvalid4), .rerr(rerr4), .werr(werr4),
    .ev_rd(ev_rd), .ev_wr(ev_wr), .cfg_count_en(en4), .cfg_wr_rd_ratio(ratio4),
    .cfg_use_merr_resp(merr4), .irq(irq4)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic [31:0] d4,
                          output logic v, output logic e);
    ren = 1'b1;
    raddr = a;
    tick(1);
    ren = 1'b0;
    raddr = '0;
    d = rdata;
    d4 = rdata4;
    v = rvalid;
    e = rerr;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] dat, output logic e);
    wen = 1'b1;
    waddr = a;
    wdata = dat;
    tick(1);
    wen = 1'b0;
    e = werr;
  endtask

  task automatic edges(input logic rd, input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      if (rd) ev_rd[ch] = 1'b1; else ev_wr[ch] = 1'b1;
      tick(2);
      if (rd) ev_rd[ch] = 1'b0; else ev_wr[ch] = 1'b0;
      tick(2);
    end
    tick(4);
  endtask

  task automatic test_reset;
    logic [31:0] d, d4;
    logic v, e;
    total++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin bad++; $display("FAIL reset_rd: rvalid=%b rdata=%h want 0/0", rvalid, rdata); end
    total++; if (rerr !== 1'b0 || werr !== 1'b0 || irq !== 1'b0) begin bad++; $display("FAIL reset_flags: rerr=%b werr=%b irq=%b want 0", rerr, werr, irq); end
    total++; if (en !== 1'b1 || ratio !== 3'd0 || merr !== 1'b0) begin bad++; $display("FAIL reset_cfg: en=%b ratio=%0d merr=%b want 1/0/0", en, ratio, merr); end
    bus_read(BASE + 32'h100, d, d4, v, e);
    total++; if (d !== 32'h1 || v !== 1'b1 || e !== 1'b0) begin bad++; $display("FAIL reset_ctrl: got %h v=%b e=%b want 00000001 1 0", d, v, e); end
    bus_read(BASE + 32'h104, d, d4, v, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_thresh: got %h want 0", d); end
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL reset_rvalid_hold: got %b want 1", rvalid); end
    tick(1);
    total++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin bad++; $display("FAIL idle_rvalid: rvalid=%b rdata=%h want 0/0", rvalid, rdata); end
  endtask

  task automatic test_count;
    logic [31:0] d, d4;
    logic v, e;
    edges(1'b0, 1, 3);
    bus_read(BASE + 32'h4, d, d4, v, e);
    total++; if (d !== 32'h3 || v !== 1'b1) begin bad++; $display("FAIL cnt_ch1: got %h v=%b want 00000003 1", d, v); end
    bus_read(BASE + 32'h4, d, d4, v, e);
    total++; if (d !== 32'h0 || v !== 1'b1) begin bad++; $display("FAIL cnt_ch1_clr: got %h v=%b want 0 1", d, v); end
    edges(1'b1, 0, 2);
    edges(1'b0, 0, 1);
    bus_read(BASE, d, d4, v, e);
    total++; if (d !== 32'h801) begin bad++; $display("FAIL cnt_ch0_mix: got %h want 00000801", d); end
    total++; if (d4 !== 32'h21) begin bad++; $display("FAIL cnt4_ch0_mix: got %h want 00000021", d4); end
  endtask

  task automatic test_saturate;
    logic [31:0] d, d4;
    logic v, e;
    edges(1'b1, 0, 20);
    bus_read(BASE, d, d4, v, e);
    total++; if (d4 !== 32'hF0) begin bad++; $display("FAIL sat_cnt4: got %h want 000000f0", d4); end
    total++; if (d !== 32'h5000) begin bad++; $display("FAIL nosat_cnt10: got %h want 00005000", d); end
  endtask

  task automatic test_clear_collision;
    logic [31:0] d, d4;
    logic v, e;
    edges(1'b0, 2, 2);
    ev_wr[2] = 1'b1;
    tick(3);
    bus_read(BASE + 32'h8, d, d4, v, e);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL coll_preclear: got %h want 00000002", d); end
    ev_wr[2] = 1'b0;
    tick(4);
    bus_read(BASE + 32'h8, d, d4, v, e);
    total++; if (d !== 32'h1 || d4 !== 32'h1) begin bad++; $display("FAIL coll_after: got %h/%h want 00000001", d, d4); end
  endtask

  task automatic test_irq;
    logic [31:0] d, d4;
    logic v, e;
    bus_write(BASE + 32'h104, 32'd5, e);
    bus_write(BASE + 32'h10C, 32'h1, e);
    edges(1'b0, 0, 4);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early: got %b want 0", irq); end
    edges(1'b0, 0, 1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_thresh: got %b want 1", irq); end
    bus_read(BASE + 32'h108, d, d4, v, e);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL irq_stat: got %h want 00000001", d); end
    bus_write(BASE + 32'h108, 32'h1, e);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_w1c: got %b want 0", irq); end
    bus_read(BASE + 32'h108, d, d4, v, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL irq_stat_clr: got %h want 0", d); end
    bus_read(BASE, d, d4, v, e);
    total++; if (d !== 32'h5) begin bad++; $display("FAIL irq_cnt: got %h want 00000005", d); end
    bus_write(BASE + 32'h104, 32'd0, e);
    bus_write(BASE + 32'h10C, 32'd0, e);
  endtask

  task automatic test_back_to_back;
    logic [31:0] d, d4;
    logic v, e;
    ren = 1'b1; raddr = BASE + 32'h104;
    wen = 1'b1; waddr = BASE + 32'h104; wdata = 32'd7;
    tick(1);
    ren = 1'b0; wen = 1'b0;
    total++; if (rdata !== 32'h0 || rvalid !== 1'b1) begin bad++; $display("FAIL same_addr_prewrite: got %h v=%b want 0 1", rdata, rvalid); end
    bus_read(BASE + 32'h104, d, d4, v, e);
    total++; if (d !== 32'h7) begin bad++; $display("FAIL same_addr_post: got %h want 00000007", d); end
    ren = 1'b1; raddr = BASE + 32'h100;
    wen = 1'b1; waddr = BASE + 32'h10C; wdata = 32'hA;
    tick(1);
    ren = 1'b0; wen = 1'b0;
    total++; if (rdata !== 32'h1) begin bad++; $display("FAIL diff_addr_rd: got %h want 00000001", rdata); end
    bus_read(BASE + 32'h10C, d, d4, v, e);
    total++; if (d !== 32'hA) begin bad++; $display("FAIL diff_addr_wr: got %h want 0000000a", d); end
    bus_write(BASE + 32'h104, 32'd0, e);
    bus_write(BASE + 32'h10C, 32'd0, e);
  endtask

  task automatic test_unmapped;
    logic [31:0] d, d4;
    logic v, e;
    bus_read(BASE + 32'h200, d, d4, v, e);
    total++; if (e !== 1'b1 || v !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL rerr: e=%b v=%b d=%h want 1 1 0", e, v, d); end
    tick(1);
    total++; if (rerr !== 1'b0) begin bad++; $display("FAIL rerr_pulse: got %b want 0", rerr); end
    bus_write(BASE + 32'h2FC, 32'hFFFF_FFFF, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL werr: got %b want 1", e); end
    tick(1);
    total++; if (werr !== 1'b0) begin bad++; $display("FAIL werr_pulse: got %b want 0", werr); end
    bus_read(BASE + 32'h100, d, d4, v, e);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL werr_ctrl: got %h want 00000001", d); end
  endtask

  task automatic test_count_disable;
    logic [31:0] d, d4;
    logic v, e;
    bus_write(BASE + 32'h100, 32'h0, e);
    total++; if (en !== 1'b0) begin bad++; $display("FAIL ctrl_en_off: got %b want 0", en); end
    edges(1'b1, 3, 4);
    bus_read(BASE + 32'hC, d, d4, v, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL disabled_cnt: got %h want 0", d); end
    bus_write(BASE + 32'h100, 32'hFFFF_FFFF, e);
    total++; if (en !== 1'b1 || ratio !== 3'd7 || merr !== 1'b1) begin bad++; $display("FAIL ctrl_fields: en=%b ratio=%0d merr=%b want 1/7/1", en, ratio, merr); end
    bus_read(BASE + 32'h100, d, d4, v, e);
    total++; if (d !== 32'h1F) begin bad++; $display("FAIL ctrl_rb: got %h want 0000001f", d); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d, d4;
    logic v, e;
    ev_wr[0] = 1'b1;
    ren = 1'b1; raddr = BASE + 32'h100;
    tick(1);
    #2 rstn = 1'b0;
    #1;
    total++; if (rvalid !== 1'b0 || rdata !== 32'h0 || rerr !== 1'b0 || werr !== 1'b0 || irq !== 1'b0) begin
      bad++; $display("FAIL midreset_out: rvalid=%b rdata=%h rerr=%b werr=%b irq=%b want 0", rvalid, rdata, rerr, werr, irq);
    end
    total++; if (en !== 1'b1 || ratio !== 3'd0 || merr !== 1'b0) begin bad++; $display("FAIL midreset_cfg: en=%b ratio=%0d merr=%b want 1/0/0", en, ratio, merr); end
    ren = 1'b0;
    tick(1);
    rstn = 1'b1;
    tick(8);
    bus_read(BASE, d, d4, v, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL level_at_release: got %h want 0", d); end
    bus_read(BASE + 32'h100, d, d4, v, e);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL midreset_ctrl: got %h want 00000001", d); end
    ev_wr[0] = 1'b0;
    tick(2);
  endtask

  initial begin
    tick(3);
    rstn = 1'b1;
    tick(2);
    test_reset();
    test_count();
    test_saturate();
    test_clear_collision();
    test_irq();
    test_back_to_back();
    test_unmapped();
    test_count_disable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
